// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Shares one SDRAM controller between three burst requesters:
//   p1 - program cache (read-only)
//   p2 - data cache (fill / writeback)
//   p3 - video / DMA port (address relative to P3_BASE)
// Each grant is one 4-word burst. Beat strobes, beat offsets and write data
// are routed to and from the granted port only. Read data (from_mem) goes to
// every requester directly, so it is not routed through this block.
//
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   pN_req / pN_wren / pN_address  burst requests (p1 has no wren)
//   pN_to_mem                      write data for beat pN_offset (p2, p3)
//   pN_ready / pN_offset           beat strobe and beat index to requester N
//   mem_req / mem_wren             burst request and direction to controller
//   mem_address / mem_to_mem       burst base address and write data
//   mem_ready / mem_offset         controller beat strobe and index
//   from_mem                       controller read data
//
// Build option: ARB_ROUND_ROBIN_EN selects rotating priority
// (p1 -> p2 -> p3 -> p1) instead of fixed priority p3 > p2 > p1.

module sdram_port_arbiter #(
    parameter int unsigned       MEM_AW  = 24,
    parameter logic [MEM_AW-1:0] P3_BASE = MEM_AW'(24'hFE0000)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p1_req,
    input  logic [31:0]       p1_address,
    output logic              p1_ready,
    output logic [1:0]        p1_offset,

    input  logic              p2_req,
    input  logic              p2_wren,
    input  logic [31:0]       p2_address,
    input  logic [15:0]       p2_to_mem,
    output logic              p2_ready,
    output logic [1:0]        p2_offset,

    input  logic              p3_req,
    input  logic              p3_wren,
    input  logic [16:0]       p3_address,
    input  logic [15:0]       p3_to_mem,
    output logic              p3_ready,
    output logic [1:0]        p3_offset,

    output logic              mem_req,
    output logic              mem_wren,
    output logic [MEM_AW-1:0] mem_address,
    output logic [15:0]       mem_to_mem,
    input  logic              mem_ready,
    input  logic [1:0]        mem_offset,
    input  logic [15:0]       from_mem
);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    localparam logic [1:0] GntNone = 2'd0;
    localparam logic [1:0] GntP1   = 2'd1;
    localparam logic [1:0] GntP2   = 2'd2;
    localparam logic [1:0] GntP3   = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  winner;
    logic        last_beat;
    logic [MEM_AW-1:0] p3_sum;

    assign last_beat = mem_ready && (mem_offset == 2'd3);
    // Wraps modulo 2^MEM_AW by construction.
    assign p3_sum = P3_BASE + {{(MEM_AW-17){1'b0}}, p3_address};

`ifdef ARB_ROUND_ROBIN_EN
    // Last winner: 0 = p1, 1 = p2, 2 = p3. The port after it ranks first.
    logic [1:0] last_q, last_d;

    always_comb begin
        winner = GntNone;
        case (last_q)
            2'd0: begin
                if      (p2_req) winner = GntP2;
                else if (p3_req) winner = GntP3;
                else if (p1_req) winner = GntP1;
            end
            2'd1: begin
                if      (p3_req) winner = GntP3;
                else if (p1_req) winner = GntP1;
                else if (p2_req) winner = GntP2;
            end
            default: begin
                if      (p1_req) winner = GntP1;
                else if (p2_req) winner = GntP2;
                else if (p3_req) winner = GntP3;
            end
        endcase
    end
`else
    always_comb begin
        winner = GntNone;
        if      (p3_req) winner = GntP3;
        else if (p2_req) winner = GntP2;
        else if (p1_req) winner = GntP1;
    end
`endif

    // State, grant and (optionally) last-winner registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= GntNone;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (winner != GntNone) begin
                    state_d = StBusy;
                    grant_d = winner;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = winner - 2'd1;
`endif
                end
            end
            StBusy: begin
                // Requests are ignored until the final beat completes the burst.
                if (last_beat) begin
                    state_d = StRelease;
                    grant_d = GntNone;
                end
            end
            StRelease: begin
                // Dead cycle so the previous winner can drop a stale req.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = GntNone;
            end
        endcase
    end

    // Output routing; everything is quiet outside a burst.
    always_comb begin
        mem_req     = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_to_mem  = 16'h0000;
        p1_ready    = 1'b0;
        p2_ready    = 1'b0;
        p3_ready    = 1'b0;
        p1_offset   = 2'd0;
        p2_offset   = 2'd0;
        p3_offset   = 2'd0;
        if (state_q == StBusy) begin
            mem_req = 1'b1;
            case (grant_q)
                GntP1: begin
                    mem_address = {p1_address[MEM_AW-1:2], 2'b00};
                    p1_ready    = mem_ready;
                    p1_offset   = mem_offset;
                end
                GntP2: begin
                    mem_wren    = p2_wren;
                    mem_address = {p2_address[MEM_AW-1:2], 2'b00};
                    mem_to_mem  = p2_to_mem;
                    p2_ready    = mem_ready;
                    p2_offset   = mem_offset;
                end
                GntP3: begin
                    mem_wren    = p3_wren;
                    mem_address = {p3_sum[MEM_AW-1:2], 2'b00};
                    mem_to_mem  = p3_to_mem;
                    p3_ready    = mem_ready;
                    p3_offset   = mem_offset;
                end
                default: ;
            endcase
        end
    end

    // Address bits dropped by the burst alignment and the shared read bus.
    logic unused_inputs;
    assign unused_inputs = ^{p1_address, p2_address, p3_sum[1:0], from_mem};

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p1_req, p2_req, p2_wren, p3_req, p3_wren;
    logic [31:0] p1_address, p2_address;
    logic [16:0] p3_address;
    logic [15:0] p2_to_mem, p3_to_mem, from_mem;
    logic        mem_ready;
    logic [1:0]  mem_offset;

    logic        p1_ready, p2_ready, p3_ready, mem_req, mem_wren;
    logic [1:0]  p1_offset, p2_offset, p3_offset;
    logic [23:0] mem_address;
    logic [15:0] mem_to_mem;

    logic        w_p1_ready, w_p2_ready, w_p3_ready, w_mem_req, w_mem_wren;
    logic [1:0]  w_p1_offset, w_p2_offset, w_p3_offset;
    logic [23:0] w_mem_address;
    logic [15:0] w_mem_to_mem;

    sdram_port_arbiter #(.MEM_AW(24), .P3_BASE(24'hFE0000)) dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p1_address(p1_address), .p1_ready(p1_ready), .p1_offset(p1_offset),
        .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
        .p2_ready(p2_ready), .p2_offset(p2_offset),
        .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
        .p3_ready(p3_ready), .p3_offset(p3_offset),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_to_mem(mem_to_mem), .mem_ready(mem_ready), .mem_offset(mem_offset),
        .from_mem(from_mem)
    );

    // Second instance with a base that makes the p3 sum wrap.
    sdram_port_arbiter #(.MEM_AW(24), .P3_BASE(24'hFF0000)) dut_wrap (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p1_address(p1_address), .p1_ready(w_p1_ready), .p1_offset(w_p1_offset),
        .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
        .p2_ready(w_p2_ready), .p2_offset(w_p2_offset),
        .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
        .p3_ready(w_p3_ready), .p3_offset(w_p3_offset),
        .mem_req(w_mem_req), .mem_wren(w_mem_wren), .mem_address(w_mem_address),
        .mem_to_mem(w_mem_to_mem), .mem_ready(mem_ready), .mem_offset(mem_offset),
        .from_mem(from_mem)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which port owns the bus, cycles left before arbitration,
    // and the last winner (0 = p1, 1 = p2, 2 = p3).
    int m_port = 0;
    int m_gap  = 0;
    int m_last = 0;

    function automatic int pick(bit r1, bit r2, bit r3, int last);
        bit r[4];
        r[1] = r1; r[2] = r2; r[3] = r3;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int cand = ((last + k) % 3) + 1;
            if (r[cand]) return cand;
        end
        return 0;
`else
        if (last < 0) return 0;
        for (int cand = 3; cand >= 1; cand--) if (r[cand]) return cand;
        return 0;
`endif
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_port = 0; m_gap = 0; m_last = 0;
        end else if (m_port != 0) begin
            if (mem_ready && mem_offset == 2'd3) begin
                m_port = 0; m_gap = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            int w = pick(p1_req, p2_req, p3_req, m_last);
            if (w != 0) begin
                m_port = w; m_last = w - 1;
            end
        end
    endtask

    function automatic logic [23:0] exp_addr(int port, longint base);
        longint s;
        logic [23:0] t;
        case (port)
            1: t = p1_address[23:0];
            2: t = p2_address[23:0];
            default: begin
                s = (base + longint'(p3_address)) % 64'd16777216;
                t = s[23:0];
            end
        endcase
        return {t[23:2], 2'b00};
    endfunction

    task automatic check_all();
        chk("mem_req", mem_req, m_port != 0);
        chk("wrap_mem_req", w_mem_req, m_port != 0);
        chk("p1_ready", p1_ready, m_port == 1 && mem_ready);
        chk("p2_ready", p2_ready, m_port == 2 && mem_ready);
        chk("p3_ready", p3_ready, m_port == 3 && mem_ready);
        chk("p1_offset", p1_offset, m_port == 1 ? mem_offset : 2'd0);
        chk("p2_offset", p2_offset, m_port == 2 ? mem_offset : 2'd0);
        chk("p3_offset", p3_offset, m_port == 3 ? mem_offset : 2'd0);
        chk("mem_wren", mem_wren, m_port == 2 ? p2_wren : (m_port == 3 ? p3_wren : 1'b0));
        if (m_port != 0) begin
            chk("mem_address", mem_address, exp_addr(m_port, 64'hFE0000));
            chk("wrap_mem_address", w_mem_address, exp_addr(m_port, 64'hFF0000));
            if (m_port == 2) chk("mem_to_mem", mem_to_mem, p2_to_mem);
            if (m_port == 3) chk("mem_to_mem", mem_to_mem, p3_to_mem);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        p1_req = 0; p2_req = 0; p3_req = 0;
        mem_ready = 0; mem_offset = 0;
        step(); step();
        reset = 1'b1;
    endtask

    // Serve one burst: wait (bounded) for mem_req, then give 4 beats.
    task automatic serve_burst(input bit drop, output int g, output int waited);
        waited = 0;
        g = 0;
        mem_ready = 0;
        #1;
        while (!mem_req && waited < 8) begin
            step(); #1; waited++;
        end
        chk("burst_start", mem_req, 1'b1);
        for (int b = 0; b < 4; b++) begin
            mem_ready = 1; mem_offset = 2'(b);
            #1;
            if (p1_ready) g = 1;
            if (p2_ready) g = 2;
            if (p3_ready) g = 3;
            chk("ready_onehot", 32'(p1_ready) + 32'(p2_ready) + 32'(p3_ready), 1);
            step();
        end
        mem_ready = 0;
        if (drop) begin
            if (g == 1) p1_req = 0;
            if (g == 2) p2_req = 0;
            if (g == 3) p3_req = 0;
        end
    endtask

    typedef struct {
        int          port;
        bit          wren;
        logic [31:0] addr;
        logic [23:0] exp_addr;
        logic [23:0] exp_wrap;
        bit          exp_wren;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   g, waited;
        int   order_drop[3];
        int   order_hold[6];
        bit   pend[4];
        int   cb;

        vecs[0] = '{1, 1'b1, 32'h0000_1235, 24'h001234, 24'h001234, 1'b0};
        vecs[1] = '{2, 1'b1, 32'h12AB_CDEF, 24'hABCDEC, 24'hABCDEC, 1'b1};
        vecs[2] = '{2, 1'b0, 32'h0000_0003, 24'h000000, 24'h000000, 1'b0};
        vecs[3] = '{3, 1'b0, 32'h0001_FFFF, 24'hFFFFFC, 24'h00FFFC, 1'b0};
        vecs[4] = '{3, 1'b1, 32'h0000_0005, 24'hFE0004, 24'hFF0004, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
        order_drop = '{2, 3, 1};
        order_hold = '{2, 3, 1, 2, 3, 1};
`else
        order_drop = '{3, 2, 1};
        order_hold = '{3, 3, 3, 3, 3, 3};
`endif

        reset = 0; p1_req = 0; p2_req = 0; p3_req = 0; p2_wren = 0; p3_wren = 0;
        p1_address = 0; p2_address = 0; p3_address = 0; p2_to_mem = 0; p3_to_mem = 0;
        from_mem = 16'h5A5A; mem_ready = 0; mem_offset = 0;

        // Reset state, with a request and controller strobe present.
        step();
        p1_req = 1; mem_ready = 1; mem_offset = 2;
        step(); #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_p1_offset", p1_offset, 0);
        chk("rst_p2_offset", p2_offset, 0);
        chk("rst_p3_offset", p3_offset, 0);
        do_reset();

        // Single-port bursts from the vector table.
        foreach (vecs[i]) begin
            p1_address = vecs[i].addr; p2_address = vecs[i].addr; p3_address = vecs[i].addr[16:0];
            p2_wren = (vecs[i].port == 2) ? vecs[i].wren : ~vecs[i].wren;
            p3_wren = (vecs[i].port == 3) ? vecs[i].wren : ~vecs[i].wren;
            if (vecs[i].port == 1) begin p2_wren = 1; p3_wren = 1; end
            p1_req = (vecs[i].port == 1);
            p2_req = (vecs[i].port == 2);
            p3_req = (vecs[i].port == 3);
            step(); #1;
            chk("vec_mem_req", mem_req, 1);
            chk("vec_mem_address", mem_address, vecs[i].exp_addr);
            chk("vec_wrap_address", w_mem_address, vecs[i].exp_wrap);
            chk("vec_mem_wren", mem_wren, vecs[i].exp_wren);
            for (int b = 0; b < 4; b++) begin
                mem_ready = 1; mem_offset = 2'(b);
                p2_to_mem = 16'hA000 + 16'(b); p3_to_mem = 16'hB000 + 16'(b);
                #1;
                chk("vec_ready", {p3_ready, p2_ready, p1_ready}, 3'b001 << (vecs[i].port - 1));
                chk("vec_offset", {p3_offset, p2_offset, p1_offset},
                    6'(b) << (2 * (vecs[i].port - 1)));
                if (vecs[i].port == 2) chk("vec_to_mem", mem_to_mem, 16'hA000 + 16'(b));
                if (vecs[i].port == 3) chk("vec_to_mem", mem_to_mem, 16'hB000 + 16'(b));
                step();
            end
            p1_req = 0; p2_req = 0; p3_req = 0;
            mem_ready = 1; mem_offset = 3;
            #1;
            chk("release_mem_req", mem_req, 0);
            chk("release_ready", {p3_ready, p2_ready, p1_ready}, 0);
            step(); #1;
            chk("idle_mem_req", mem_req, 0);
            mem_ready = 0;
            step();
        end

        // Contention, each winner drops its req after its burst.
        do_reset();
        p2_wren = 0; p3_wren = 0;
        p1_req = 1; p2_req = 1; p3_req = 1;
        for (int i = 0; i < 3; i++) begin
            serve_burst(1'b1, g, waited);
            chk("order_drop", g, order_drop[i]);
        end

        // Contention, all requests held throughout.
        do_reset();
        p1_req = 1; p2_req = 1; p3_req = 1;
        for (int i = 0; i < 6; i++) begin
            serve_burst(1'b0, g, waited);
            chk("order_hold", g, order_hold[i]);
            if (i > 0) chk("burst_gap", waited, 2);
        end

        // Reset at beat 1 of a p2 burst, then a normal p1 burst.
        do_reset();
        p2_req = 1; p2_wren = 1; p1_address = 32'h0000_0ABC;
        step();
        mem_ready = 1; mem_offset = 0; step();
        mem_offset = 1; reset = 0; step();
        reset = 1; p2_req = 0; p1_req = 1;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_p2_ready", p2_ready, 0);
        serve_burst(1'b1, g, waited);
        chk("after_abort_grant", g, 1);
        chk("after_abort_wait", waited, 1);

        // Randomized traffic against the model.
        do_reset();
        pend = '{0, 0, 0, 0};
        cb = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  was;
            bit  beat, last;
            if (!pend[1] && $urandom_range(3) == 0) begin
                pend[1] = 1; p1_req = 1; p1_address = $urandom;
            end
            if (!pend[2] && $urandom_range(3) == 0) begin
                pend[2] = 1; p2_req = 1; p2_wren = 1'($urandom); p2_address = $urandom;
            end
            if (!pend[3] && $urandom_range(3) == 0) begin
                pend[3] = 1; p3_req = 1; p3_wren = 1'($urandom); p3_address = 17'($urandom);
            end
            p2_to_mem = 16'($urandom); p3_to_mem = 16'($urandom); from_mem = 16'($urandom);
            if (m_port != 0) begin
                mem_ready = ($urandom_range(2) != 0); mem_offset = 2'(cb);
            end else begin
                mem_ready = 1'($urandom); mem_offset = 2'($urandom);
            end
            #1;
            check_all();
            was  = m_port;
            beat = (m_port != 0) && mem_ready;
            last = beat && (mem_offset == 2'd3);
            step();
            if (beat) cb = (cb + 1) % 4;
            if (last) begin
                pend[was] = 0;
                if (was == 1) p1_req = 0;
                if (was == 2) p2_req = 0;
                if (was == 3) p3_req = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Three-port arbiter that shares the single SDRAM controller between the program cache (p1), the data cache (p2) and the video/DMA port (p3). It sits between the cache/video request ports and the SDRAM controller. Each grant is one 4-word burst, read or write. Data and offsets are routed to and from the granted port only.

## Interface
Parameters:
- MEM_AW, 24: width of the controller word address.
- P3_BASE, 24'hFE0000: base word address added to the 17-bit p3 address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- p1_req  in  1  program cache burst request, read-only.
- p1_address  in  32  p1 burst word address; low 2 bits ignored.
- p1_ready  out  1  p1 data word valid on from_mem.
- p1_offset  out  2  word index of current p1 beat.
- p2_req  in  1  data cache burst request.
- p2_wren  in  1  1 = writeback burst, 0 = fill.
- p2_address  in  32  p2 burst word address; low 2 bits ignored.
- p2_to_mem  in  16  p2 write data for word p2_offset.
- p2_ready  out  1  p2 beat accepted (write) or valid (read).
- p2_offset  out  2  word index of current p2 beat.
- p3_req  in  1  video port burst request.
- p3_wren  in  1  p3 write flag.
- p3_address  in  17  p3 word address, relative to P3_BASE.
- p3_to_mem  in  16  p3 write data.
- p3_ready  out  1  p3 beat strobe.
- p3_offset  out  2  word index of current p3 beat.
- mem_req  out  1  burst request to SDRAM controller.
- mem_wren  out  1  burst direction to controller.
- mem_address  out  MEM_AW  burst base address, low 2 bits forced 0.
- mem_to_mem  out  16  write data to controller.
- mem_ready  in  1  controller beat strobe.
- mem_offset  in  2  controller beat index 0..3.
- from_mem  in  16  read data; fanned out unchanged to all ports.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: at each clock edge, if any pN_req is high, latch the winner into a grant register and go to BUSY. Otherwise stay in IDLE.
- BUSY: mem_req=1. mem_wren, mem_address and mem_to_mem come from the granted port. p1 is forced to mem_wren=0.
- BUSY beat routing: pN_ready = mem_ready & (grant==N). pN_offset = mem_offset for the granted port and 0 for all other ports. mem_to_mem is the granted port's to_mem, selected combinationally from the live mem_offset.
- BUSY exit: a beat with mem_ready=1 and mem_offset==3 ends the burst. Go to RELEASE; mem_req deasserts on that edge.
- RELEASE: one cycle with no grant. This gives the requester time to drop req, so a stale req is never re-granted. Then go to IDLE.
- A requester holds req, wren and address stable from assertion until its last ready. Dropping req mid-burst is a protocol violation; the arbiter ignores it and completes the burst.
- Address mapping: p1/p2 use address[MEM_AW-1:0]. p3 uses P3_BASE + {7'b0, p3_address}, modulo 2^MEM_AW. In all cases bits [1:0] are forced to 0.
- Fixed-priority mode (default): p3 > p2 > p1.

## Timing
- Reset (reset=0 at an edge): state=IDLE, grant=none, mem_req=0, all pN_ready=0, all pN_offset=0, mem_wren=0.
- Reset mid-burst aborts the burst at once. mem_req=0 on the next cycle; the controller must also be reset.
- Request to mem_req latency: 1 cycle. A req seen high at edge k gives mem_req=1 after edge k.
- pN_ready and pN_offset are combinational from mem_ready/mem_offset, with zero added latency.
- Minimum burst-to-burst gap: 1 idle cycle (RELEASE) plus 1 arbitration cycle (IDLE).
- Simultaneous requests in IDLE are resolved by the priority or round-robin rule. The losers stay pending.
- mem_ready while in IDLE or RELEASE is ignored, and no pN_ready is raised.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: a 2-bit last-granted register (reset value 0 = p1) rotates priority, so the port after the last winner has highest priority. Order is p1→p2→p3→p1.
  - Undefined: fixed priority p3 > p2 > p1, and the register is absent.

## Test plan
- Single p1 read: p1_req=1, address 0x0000_1235. Expect mem_address=0x001234 and mem_wren=0 one cycle later. Controller beats 0..3 give p1_ready ×4 with p1_offset 0,1,2,3. mem_req drops after beat 3, followed by 1 RELEASE cycle.
- p2 writeback: p2_req=p2_wren=1, with to_mem driven as 0xA000+p2_offset. Expect mem_to_mem 0xA000..0xA003 on beats 0..3 and mem_wren=1.
- p3 mapping: p3_address=0x1FFFF with P3_BASE=0xFE0000. Expect mem_address=0xFFFFFC. With P3_BASE=0xFF0000 the sum wraps to 0x00FFFC.
- Contention, fixed priority: p1, p2 and p3 asserted together. Expect grants in order p3, p2, p1, with no ready on non-granted ports.
- Contention with ARB_ROUND_ROBIN_EN: all three held continuously for 6 bursts. Expect grants p2, p3, p1, p2, p3, p1.
- Reset at beat 1 of a p2 burst: expect mem_req=0 and p2_ready=0 the next cycle, and state IDLE. A new p1_req is then granted normally.
